// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply (radix-2 shift-add) / divide (restoring) unit.
// Fixed 32-iteration latency; one-cycle ready pulse with exception flag and rstatus code.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy,
  output logic [31:0] rstatus_value
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_cnt;
  logic        r_is_mul;
  logic        r_neg;
  logic        r_div_exc;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplr;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;
  logic        r_busy;
  logic [31:0] r_rstatus;

  logic        w_start;
  logic        w_last;
  logic [31:0] w_magA;
  logic [31:0] w_magB;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic        w_mul_ovf;
  logic [32:0] w_shift;
  logic        w_fits;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic [31:0] w_quo_signed;

  assign w_start = (r_state == S_IDLE) && (ctrl_MULT || ctrl_DIV);
  assign w_last  = (r_state == S_CALC) && (r_cnt == 6'd31);
  assign w_magA  = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign w_magB  = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Multiply step: add shifted multiplicand when the current multiplier bit is set.
  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : 64'd0);
  assign w_prod     = r_neg ? (64'd0 - w_acc_next) : w_acc_next;
  assign w_mul_ovf  = (w_prod[63:32] != {32{w_prod[31]}});

  // Divide step: shift rem:quo left, trial-subtract divisor, keep shifted value if it would go negative.
  assign w_shift      = {r_rem, r_quo[31]};
  assign w_fits       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next   = w_fits ? (w_shift[31:0] - r_divisor) : w_shift[31:0];
  assign w_quo_next   = {r_quo[30:0], w_fits};
  assign w_quo_signed = r_neg ? (32'd0 - w_quo_next) : w_quo_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (ctrl_MULT || ctrl_DIV) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == 6'd31) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_is_mul  <= 1'b0;
      r_neg     <= 1'b0;
      r_div_exc <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_exc     <= 1'b0;
      r_rdy     <= 1'b0;
      r_busy    <= 1'b0;
      r_rstatus <= '0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_is_mul  <= ctrl_MULT;
      r_neg     <= data_operandA[31] ^ data_operandB[31];
      r_div_exc <= (data_operandB == 32'd0) ||
                   ((data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF));
      r_acc     <= '0;
      r_mcand   <= {32'd0, w_magA};
      r_mplr    <= w_magB;
      r_rem     <= '0;
      r_quo     <= w_magA;
      r_divisor <= w_magB;
      r_busy    <= 1'b1;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + 6'd1;
      if (r_is_mul) begin
        r_acc   <= w_acc_next;
        r_mcand <= {r_mcand[62:0], 1'b0};
        r_mplr  <= {1'b0, r_mplr[31:1]};
      end else begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end
      if (w_last) begin
        r_rdy <= 1'b1;
        if (r_is_mul) begin
          r_result  <= w_prod[31:0];
          r_exc     <= w_mul_ovf;
          r_rstatus <= w_mul_ovf ? 32'd4 : 32'd0;
        end else if (r_div_exc) begin
          r_result  <= '0;
          r_exc     <= 1'b1;
          r_rstatus <= 32'd5;
        end else begin
          r_result  <= w_quo_signed;
          r_exc     <= 1'b0;
          r_rstatus <= '0;
        end
      end
    end else if (r_state == S_DONE) begin
      r_rdy  <= 1'b0;
      r_busy <= 1'b0;
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
  assign rstatus_value  = r_rstatus;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: cycle-level behavioural model with a per-cycle
// compare process, plus directed vectors checked against hand-computed values.
module tb_multdiv_unit;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  logic [31:0] rstatus_value;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          chk_en = 1'b0;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy),
    .rstatus_value  (rstatus_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from signed arithmetic.
  task automatic model_calc(input logic [31:0] a, input logic [31:0] b, input bit is_mul,
                            output logic [31:0] res, output logic exc, output logic [31:0] rs);
    longint p;
    int     q;
    if (is_mul) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
      rs  = exc ? 32'd4 : 32'd0;
    end else if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      res = 32'd0;
      exc = 1'b1;
      rs  = 32'd5;
    end else begin
      q   = $signed(a) / $signed(b);
      res = q;
      exc = 1'b0;
      rs  = 32'd0;
    end
  endtask

  // Cycle model: m_left counts cycles still busy after the start edge (33 = 32 CALC + DONE).
  int unsigned m_left;
  logic [31:0] m_pres, m_prs, m_res, m_rs;
  logic        m_pexc, m_exc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0;
      m_res  <= '0;
      m_exc  <= 1'b0;
      m_rs   <= '0;
    end else if (m_left == 0) begin
      if (ctrl_MULT || ctrl_DIV) begin
        logic [31:0] r, s;
        logic        e;
        model_calc(data_operandA, data_operandB, ctrl_MULT, r, e, s);
        m_pres <= r;
        m_pexc <= e;
        m_prs  <= s;
        m_left <= 33;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res <= m_pres;
        m_exc <= m_pexc;
        m_rs  <= m_prs;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, m_left != 0});
      chk("cyc_rdy", {31'd0, data_resultRDY}, {31'd0, m_left == 1});
      chk("cyc_result", data_result, m_res);
      chk("cyc_exc", {31'd0, data_exception}, {31'd0, m_exc});
      chk("cyc_rstatus", rstatus_value, m_rs);
    end
  end

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic d, input logic [31:0] er,
                        input logic ee, input logic [31:0] ers, input bit pulse_div);
    int unsigned lat;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;
    data_operandB = ~b;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (pulse_div && i == 5) ctrl_DIV = 1'b1;
      if (pulse_div && i == 6) ctrl_DIV = 1'b0;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_latency"}, lat, 32);
    chk({nm, "_result"}, data_result, er);
    chk({nm, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    chk({nm, "_rstatus"}, rstatus_value, ers);
    chk({nm, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clock);
    #1;
    chk({nm, "_rdy_1cyc"}, {31'd0, data_resultRDY}, 32'd0);
    chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic count_rdy(input string nm, input int unsigned cycles);
    int unsigned n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) n++;
    end
    chk(nm, n, 0);
  endtask

  initial begin
    logic [31:0] r, s;
    logic        e;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    reset_n       = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rstatus", rstatus_value, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    model_calc(32'd7, 32'hFFFF_FFFD, 1'b1, r, e, s);
    chk("model_mul_7x-3", r, 32'hFFFF_FFEB);
    model_calc(32'hFFFF_FFF9, 32'd2, 1'b0, r, e, s);
    chk("model_div_-7/2", r, 32'hFFFF_FFFD);
    model_calc(32'h0001_0000, 32'h0001_0000, 1'b1, r, e, s);
    chk("model_mul_ovf_rs", s, 32'd4);

    run_op("mul_7x-3",   32'd7,          32'hFFFF_FFFD, 1, 0, 32'hFFFF_FFEB, 0, 0, 0);
    run_op("mul_-7x-3",  32'hFFFF_FFF9,  32'hFFFF_FFFD, 1, 0, 32'd21,        0, 0, 0);
    run_op("mul_2^16sq", 32'h0001_0000,  32'h0001_0000, 1, 0, 32'd0,         1, 4, 0);
    run_op("mul_min_x1", 32'h8000_0000,  32'd1,         1, 0, 32'h8000_0000, 0, 0, 0);
    run_op("mul_min_x-1",32'h8000_0000,  32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 1, 4, 0);

    // Abort a divide after 10 CALC cycles; outputs must clear at once.
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1 ctrl_DIV = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_exc", {31'd0, data_exception}, 32'd0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rstatus", rstatus_value, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    count_rdy("midrst_no_rdy", 40);

    run_op("div_100/7",  32'd100,        32'd7,         0, 1, 32'd14,        0, 0, 0);
    run_op("div_-7/2",   32'hFFFF_FFF9,  32'd2,         0, 1, 32'hFFFF_FFFD, 0, 0, 0);
    run_op("div_7/-2",   32'd7,          32'hFFFF_FFFE, 0, 1, 32'hFFFF_FFFD, 0, 0, 0);
    run_op("div_0/5",    32'd0,          32'd5,         0, 1, 32'd0,         0, 0, 0);
    run_op("div_5/0",    32'd5,          32'd0,         0, 1, 32'd0,         1, 5, 0);
    run_op("div_min/-1", 32'h8000_0000,  32'hFFFF_FFFF, 0, 1, 32'd0,         1, 5, 0);
    run_op("div_min/2",  32'h8000_0000,  32'd2,         0, 1, 32'hC000_0000, 0, 0, 0);
    run_op("both_6x3",   32'd6,          32'd3,         1, 1, 32'd18,        0, 0, 0);
    run_op("mul_pulse",  32'd6,          32'd3,         1, 0, 32'd18,        0, 0, 1);
    count_rdy("pulse_no_extra_rdy", 40);
    chk("pulse_result_held", data_result, 32'd18);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Multi-cycle signed 32-bit multiply/divide unit in the execute stage, alongside the single-cycle ALU. It runs a radix-2 shift-add multiply or a restoring divide over 32 iterations and reports completion with a one-cycle ready pulse. It flags exceptions and supplies the rstatus code (mul = 4, div = 5) to the exception/writeback path, which already handles add = 1, addi = 2, sub = 3.

## Interface
Parameters:
- none; width fixed at 32, iteration count fixed at 32.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- data_operandA  in  32  multiplicand / dividend, two's complement
- data_operandB  in  32  multiplier / divisor, two's complement
- ctrl_MULT  in  1  start multiply; sampled in IDLE only
- ctrl_DIV  in  1  start divide; sampled in IDLE only
- data_result  out  32  low 32 bits of product, or quotient
- data_exception  out  1  overflow or divide-by-zero on the completed op
- data_resultRDY  out  1  one-cycle pulse; result, exception and rstatus valid
- busy  out  1  high in CALC and DONE
- rstatus_value  out  32  4 (mul exception), 5 (div exception), else 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE to CALC on an edge with ctrl_MULT or ctrl_DIV high. That edge latches:
  - both operands;
  - op type (MULT wins if both are high);
  - result sign: sign(A) XOR sign(B);
  - magnitudes |A| and |B| as unsigned 32-bit values, so |−2^31| = 0x80000000.
- Iteration counter is 6 bits, cleared on start.
- CALC multiply: 64-bit accumulator. Each edge examines one multiplier bit, conditionally adds the shifted multiplicand, and shifts.
- CALC divide: restoring division. Each edge shifts remainder:quotient left one bit, trial-subtracts the divisor, and restores on a negative result.
- CALC to DONE on the edge that completes iteration 32. The result is finalized on that edge:
  - negate if result sign = 1;
  - multiply result = low 32 bits;
  - divide result = quotient, truncated toward zero.
- Multiply exception: the signed 64-bit product does not fit in 32 bits (upper 32 bits ≠ replication of bit 31).
- Divide exception: divisor = 0, or A = 0x80000000 with B = 0xFFFFFFFF. In both cases data_result = 0.
- rstatus_value: 4 if multiply exception, 5 if divide exception, else 0.
- DONE to IDLE unconditionally on the next edge.
- data_result, data_exception and rstatus_value hold their values until the next op completes.
- ctrl_MULT / ctrl_DIV are ignored in CALC and DONE; there is no queuing.
- Operand changes after the start edge have no effect.

## Timing
- Reset (asynchronous, any state, including mid-CALC):
  - state goes to IDLE and the counter clears;
  - data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, rstatus_value = 0;
  - the in-flight operation is discarded with no ready pulse.
- Start edge = E0. data_resultRDY is high in the cycle after E32, exactly one cycle.
- Latency is 32 cycles for every operand value, including divide-by-zero.
- busy is high from after E0 through the DONE cycle.
- Earliest next start is the edge ending the DONE cycle plus one, i.e. 34-cycle issue interval.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset mid-op: assert reset_n = 0 at cycle 10 of CALC → all outputs 0 immediately. After release, no data_resultRDY appears and a new op runs normally.
- Multiply signs: A = 7, B = −3 → after 32 cycles RDY pulses, result 0xFFFFFFEB, exception 0, rstatus 0. Repeat for −7 × −3 → 21.
- Multiply overflow:
  - 65536 × 65536 → result 0, exception 1, rstatus 4.
  - −2^31 × 1 → 0x80000000, exception 0.
  - −2^31 × −1 → exception 1, rstatus 4.
- Divide truncation: −7 / 2 → −3, exception 0. 7 / −2 → −3. 0 / 5 → 0.
- Divide exceptions:
  - 5 / 0 → result 0, exception 1, rstatus 5, RDY still at exactly 32 cycles.
  - 0x80000000 / −1 → result 0, exception 1, rstatus 5.
- Control: ctrl_MULT and ctrl_DIV together with A = 6, B = 3 → multiply, result 18. A ctrl_DIV pulse during CALC is ignored: one RDY pulse only, result unchanged.
